// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrl_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - pipeline-side hazard inputs and controller stall/flush/forward outputs
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REG_W-1:0] WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  // master is the datapath side, slave is the controller
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCycles, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// rtl/pipeline_ctrl_fwd_unit.sv - combinational E-stage operand forward select for one source operand
module pipeline_ctrl_fwd_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] wa_m,
  input  logic [REG_W-1:0] wa_w,
  input  logic             we_m,
  input  logic             we_w,
  output fwd_sel_t         sel
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  // M holds the younger result, so it wins over W
  always_comb begin
    sel = FWD_RF;
    if (we_m && (wa_m != ZERO) && (wa_m == ra)) begin
      sel = FWD_M;
    end else if (we_w && (wa_w != ZERO) && (wa_w == ra)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/sequencing controller: forwarding, load-use, memory-wait freeze, perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1),
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  pipeline_ctrl_if.slave   bus
);

  localparam logic [REG_W-1:0]  ZERO     = REG_W'(REG_ZERO);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  ctrl_state_t       state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              mem_err, err_set;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  fwd_sel_t          fwd_a, fwd_b;
  logic              ld_stall, freeze;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;
  logic [1:0]        fwd_ae, fwd_be;

  pipeline_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .ra(bus.RA1E), .wa_m(bus.WA3M), .wa_w(bus.WA3W),
    .we_m(bus.RegWriteM), .we_w(bus.RegWriteW), .sel(fwd_a)
  );

  pipeline_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .ra(bus.RA2E), .wa_m(bus.WA3M), .wa_w(bus.WA3W),
    .we_m(bus.RegWriteM), .we_w(bus.RegWriteW), .sel(fwd_b)
  );

  assign ld_stall = bus.MemToRegE && bus.RegWriteE && (bus.WA3E != ZERO) &&
                    ((bus.WA3E == bus.RA1D) || (bus.WA3E == bus.RA2D));

  assign freeze = ((state == RUN) && bus.MemReqM && !bus.MemReadyM) ||
                  ((state == MEM_WAIT) && !bus.MemReadyM) ||
                  (state == ERR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    err_set    = 1'b0;
    case (state)
      RUN: begin
        if (bus.MemReqM && !bus.MemReadyM) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.MemReadyM) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          state_n = ERR;
          err_set = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end
      end
      ERR:     state_n = ERR;
      default: state_n = RUN;
    endcase
  end

  // outputs are forced quiet while reset is held, even though inputs may be live
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_ae  = 2'b00;
    fwd_be  = 2'b00;
    if (RST_N) begin
      fwd_ae = fwd_a;
      fwd_be = fwd_b;
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        flush_d = bus.PCSrcE;
        flush_e = bus.PCSrcE || ld_stall;
        stall_f = ld_stall && !bus.PCSrcE;
        stall_d = ld_stall && !bus.PCSrcE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall_f || stall_d || stall_e || stall_m) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((flush_d || flush_e) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.ForwardAE   = fwd_ae;
  assign bus.ForwardBE   = fwd_be;
  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.StallE      = stall_e;
  assign bus.StallM      = stall_m;
  assign bus.FlushD      = flush_d;
  assign bus.FlushE      = flush_e;
  assign bus.FlushW      = flush_w;
  assign bus.MemErr      = mem_err;
  assign bus.StallCycles = stall_cnt;
  assign bus.FlushCount  = flush_cnt;

endmodule
